ser_64_8_sched: RTL and testbench
=================================

# ser_64_8_sched

Round-robin scheduler that shares one `module_64_8` 64→8 serializer between `N_SRC` word sources. It grants one 64-bit word at a time, loads it into the serializer and drains its 8 bytes. It then forwards the bytes downstream, tagged with the source index and a last-byte flag. It sits between the word producers and the serializer, and owns all serializer control pins.

## Interface
- `N_SRC`, 4: number of word sources, 2..8.
- `TIMEOUT`, 64: maximum cycles per word from load to `data_end`.
- `SRC_W`, `$clog2(N_SRC)`: source index width (derived).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  N_SRC  source i holds a word.
- `src_data`  in  N_SRC*64  word of source i at bits [64i+63:64i].
- `src_ack`  out  N_SRC  one-cycle pulse: word of source i captured.
- `ser_strobe_in`  out  1  to serializer `strobe_in`.
- `ser_input_data`  out  64  to serializer `input_data`.
- `ser_req_data`  out  1  to serializer `req_data`.
- `ser_ready`  in  1  from serializer `ready`.
- `ser_data_end`  in  1  from serializer `data_end`.
- `ser_strobe_out`  in  1  from serializer `strobe_out`.
- `ser_data_out`  in  8  from serializer `data_out`.
- `out_valid`  out  1  forwarded byte valid.
- `out_data`  out  8  forwarded byte.
- `out_src`  out  SRC_W  source of the forwarded byte.
- `out_last`  out  1  last byte of the word.
- `busy`  out  1  state ≠ IDLE.
- `err_timeout`  out  1  sticky; set when a word exceeds TIMEOUT.
- `err_len`  out  1  sticky; set when `data_end` arrives with a byte count ≠ 8.

## Operation
- Serializer contract:
  - It accepts a word on one-cycle `strobe_in`.
  - It holds `ready` high while bytes remain.
  - It emits one byte per `strobe_out` while `req_data` is high.
  - It flags the last byte with `data_end`.
- States: IDLE → LOAD → DRAIN → IDLE.
- **IDLE:** if any `src_valid`, pick the first valid source after `last_grant` (cyclic).
  - At that edge, register the word into `ser_input_data` and set `ser_strobe_in`=1.
  - Set `src_ack[g]`=1, `cur_src`=g, `last_grant`=g. Go to LOAD.
- **LOAD:** `ser_strobe_in`, `src_ack` return to 0. When `ser_ready`=1, go to DRAIN.
- **DRAIN:** `ser_req_data` is registered `ser_ready` (drops one cycle after `ready` falls).
  - Each `ser_strobe_out` increments `byte_cnt` (4 bits).
  - On `ser_strobe_out && ser_data_end`: set `err_len` if the incremented count ≠ 8; clear `byte_cnt`; go to IDLE.
- Forwarding: `out_valid/out_data/out_last` are registered copies of `ser_strobe_out/ser_data_out/ser_data_end`, and `out_src` = `cur_src`, all one cycle later. Strobes outside DRAIN are ignored.
- Timeout: `wd_cnt` counts cycles in LOAD/DRAIN. When it reaches TIMEOUT-1:
  - set `err_timeout`, clear `ser_req_data`, go to IDLE;
  - no `out_last` is emitted.
- Sources must hold `src_valid/src_data` until they see `src_ack`. A source may drop valid or present its next word on the edge where ack is high.
- `src_valid` changing during LOAD/DRAIN has no effect until IDLE.
- Errors are sticky until reset.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant`=N_SRC-1 (source 0 has first priority), counters 0.
- Reset mid-word: immediate return to IDLE. The partial word is discarded and no further `out_*` is produced.
- Latency:
  - `src_valid` sampled at edge E0 → `ser_strobe_in` and `src_ack` high for cycle E0..E1.
  - First `out_valid` = 1 cycle after the first `ser_strobe_out`.
- Back-to-back: the earliest next grant is the edge after the `data_end` byte. Minimum idle between words is 1 cycle.
- Simultaneous requests: strict rotation. No source is granted twice while another valid source waits.

## Structure
- Package `ser_64_8_pkg`: state enum `sched_state_t` {IDLE, LOAD, DRAIN}, `WORD_W`=64, `BYTE_W`=8, `BYTES_PER_WORD`=8.
- One sub-module: `rr_arbiter` (N-way round-robin pick from a request vector plus a last-grant pointer; combinational output, with a `found` flag).

## Test plan
- Reset: hold `reset_n`=0 for 10 cycles → all outputs 0, `busy`=0. Release, with no requests → idle.
- Single word: src1 word 64'h0123_4567_89AB_CDEF → one `src_ack[1]` pulse, 8 `out_valid` bytes with `out_src`=1, `out_last` on the 8th, `err_len`=0.
- Contention: all 4 sources valid continuously → grant order 0,1,2,3,0. Each word gives 8 bytes, gaps of ≥1 cycle.
- Short word: serializer model asserts `data_end` on byte 5 → `err_len`=1, back to IDLE, next word served normally.
- Stall: serializer never asserts `ready` after load → `err_timeout`=1 at cycle 64 after grant, `ser_req_data`=0, `busy`=0.
- Reset mid-DRAIN after byte 3 → outputs 0 immediately, no further `out_valid`, and after release source 0 is served first.

Source files
------------

// File: rtl/ser_64_8_pkg.sv
// Shared types and widths for the 64->8 serializer scheduler.
package ser_64_8_pkg;

  localparam int unsigned WORD_W         = 64;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } sched_state_t;

endpackage

// File: rtl/ser_64_8_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after the last grant.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt,
  output logic         found
);

  int unsigned k;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = 32'(last) + i;
      if (k >= N) k = k - N;
      if (!found && req[W'(k)]) begin
        found = 1'b1;
        gnt   = W'(k);
      end
    end
  end

endmodule

// File: rtl/ser_64_8_sched.sv
// Round-robin scheduler sharing one 64->8 serializer among N_SRC word sources.
module ser_64_8_sched
  import ser_64_8_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned SRC_W   = $clog2(N_SRC)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC*WORD_W-1:0]   src_data,
  output logic [N_SRC-1:0]          src_ack,
  output logic                      ser_strobe_in,
  output logic [WORD_W-1:0]         ser_input_data,
  output logic                      ser_req_data,
  input  logic                      ser_ready,
  input  logic                      ser_data_end,
  input  logic                      ser_strobe_out,
  input  logic [BYTE_W-1:0]         ser_data_out,
  output logic                      out_valid,
  output logic [BYTE_W-1:0]         out_data,
  output logic [SRC_W-1:0]          out_src,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_len
);

  localparam int unsigned WD_W = $clog2(TIMEOUT);

  sched_state_t        state_q, state_d;
  logic [SRC_W-1:0]    last_q, last_d, cur_q, cur_d, gnt;
  logic [3:0]          byte_q, byte_d, byte_inc;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                found, strobe_d, req_d, tmo_d, len_d, fwd;
  logic [N_SRC-1:0]    ack_d;
  logic [WORD_W-1:0]   data_d, sel_word;

  rr_arbiter #(.N(N_SRC), .W(SRC_W)) u_arb (
    .req   (src_valid),
    .last  (last_q),
    .gnt   (gnt),
    .found (found)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    byte_d   = byte_q;
    wd_d     = wd_q;
    strobe_d = 1'b0;
    ack_d    = '0;
    data_d   = ser_input_data;
    req_d    = 1'b0;
    tmo_d    = err_timeout;
    len_d    = err_len;
    byte_inc = byte_q + 4'd1;
    fwd      = (state_q == DRAIN) && ser_strobe_out;
    sel_word = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (SRC_W'(i) == gnt) sel_word = src_data[i*WORD_W +: WORD_W];
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d  = LOAD;
          data_d   = sel_word;
          strobe_d = 1'b1;
          ack_d    = N_SRC'(1) << gnt;
          cur_d    = gnt;
          last_d   = gnt;
          wd_d     = '0;
          byte_d   = '0;
        end
      end
      LOAD: begin
        if (ser_ready) state_d = DRAIN;
      end
      DRAIN: begin
        req_d = ser_ready;
        if (ser_strobe_out) begin
          byte_d = byte_inc;
          if (ser_data_end) begin
            if (byte_inc != 4'(BYTES_PER_WORD)) len_d = 1'b1;
            byte_d  = '0;
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only fires on a word that is not completing this cycle
    if (state_q != IDLE && state_d != IDLE) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        tmo_d   = 1'b1;
        req_d   = 1'b0;
        byte_d  = '0;
        state_d = IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      last_q         <= SRC_W'(N_SRC - 1);
      cur_q          <= '0;
      byte_q         <= '0;
      wd_q           <= '0;
      src_ack        <= '0;
      ser_strobe_in  <= 1'b0;
      ser_input_data <= '0;
      ser_req_data   <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_src        <= '0;
      out_last       <= 1'b0;
      busy           <= 1'b0;
      err_timeout    <= 1'b0;
      err_len        <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      cur_q          <= cur_d;
      byte_q         <= byte_d;
      wd_q           <= wd_d;
      src_ack        <= ack_d;
      ser_strobe_in  <= strobe_d;
      ser_input_data <= data_d;
      ser_req_data   <= req_d;
      out_valid      <= fwd;
      out_data       <= fwd ? ser_data_out : '0;
      out_src        <= fwd ? cur_q : '0;
      out_last       <= fwd && ser_data_end;
      busy           <= (state_d != IDLE);
      err_timeout    <= tmo_d;
      err_len        <= len_d;
    end
  end

endmodule

// File: tb/tb_ser_64_8_sched.sv
// Directed bench for ser_64_8_sched with a behavioural 64->8 serializer model.
module tb_ser_64_8_sched;

  logic          clk, reset_n;
  logic [3:0]    src_valid;
  logic [255:0]  src_data;
  logic [3:0]    src_ack;
  logic          ser_strobe_in, ser_req_data;
  logic [63:0]   ser_input_data;
  logic          m_ready, m_end, m_strobe;
  logic [7:0]    m_data;
  logic          out_valid, out_last, busy, err_timeout, err_len;
  logic [7:0]    out_data;
  logic [1:0]    out_src;

  logic [63:0]   m_word;
  int            m_rem;
  bit            stall, short_w;
  int            errors = 0;
  int            checks = 0;

  ser_64_8_sched #(.N_SRC(4), .TIMEOUT(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ack        (src_ack),
    .ser_strobe_in  (ser_strobe_in),
    .ser_input_data (ser_input_data),
    .ser_req_data   (ser_req_data),
    .ser_ready      (m_ready),
    .ser_data_end   (m_end),
    .ser_strobe_out (m_strobe),
    .ser_data_out   (m_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_src        (out_src),
    .out_last       (out_last),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .err_len        (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: LSB byte first, data_end on the last byte (5th when short_w)
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0; m_end <= 1'b0; m_strobe <= 1'b0;
      m_data <= '0; m_word <= '0; m_rem <= 0;
    end else begin
      m_strobe <= 1'b0;
      m_end    <= 1'b0;
      if (ser_strobe_in) begin
        m_word  <= ser_input_data;
        m_rem   <= short_w ? 5 : 8;
        m_ready <= !stall;
      end else if (m_ready && ser_req_data && m_rem > 0) begin
        m_strobe <= 1'b1;
        m_data   <= m_word[7:0];
        m_word   <= m_word >> 8;
        m_rem    <= m_rem - 1;
        if (m_rem == 1) begin
          m_end   <= 1'b1;
          m_ready <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i, input logic [63:0] w);
    src_valid[i] = 1'b1;
    src_data[i*64 +: 64] = w;
  endtask

  task automatic wait_ack(input logic [3:0] exp, input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (src_ack == 4'd0 && t < 200);
    check(tag, 64'(src_ack), 64'(exp));
  endtask

  // Collect a word's bytes; returns at the negedge where the last byte is visible
  task automatic collect(input int es, input logic [63:0] w, input int n, input string tag);
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_first_valid"}, 64'(out_valid), 64'd1);
    if (!out_valid) return;
    for (int k = 0; k < n; k++) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(w[8*k +: 8]));
      check({tag, "_src"}, 64'(out_src), 64'(es));
      check({tag, "_last"}, 64'(out_last), 64'(k == n - 1));
      if (k < n - 1) @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [63:0] cw [4];

  initial begin
    reset_n = 1'b0; src_valid = '0; src_data = '0; stall = 0; short_w = 0;
    for (int i = 0; i < 4; i++) cw[i] = 64'h0706_0504_0302_0100 + 64'(i) * 64'h1010_1010_1010_1010;

    // Reset state
    repeat (10) @(negedge clk);
    check("rst_ack", 64'(src_ack), 64'd0);
    check("rst_strobe_in", 64'(ser_strobe_in), 64'd0);
    check("rst_input_data", ser_input_data, 64'd0);
    check("rst_req", 64'(ser_req_data), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_timeout", 64'(err_timeout), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ack", 64'(src_ack), 64'd0);

    // Single word from source 1
    present(1, 64'h0123_4567_89AB_CDEF);
    wait_ack(4'b0010, "single_ack");
    check("single_strobe_in", 64'(ser_strobe_in), 64'd1);
    check("single_input_data", ser_input_data, 64'h0123_4567_89AB_CDEF);
    src_valid = '0;
    @(negedge clk);
    check("single_ack_pulse", 64'(src_ack), 64'd0);
    check("single_busy", 64'(busy), 64'd1);
    collect(1, 64'h0123_4567_89AB_CDEF, 8, "single");
    check("single_err_len", 64'(err_len), 64'd0);
    check("single_idle", 64'(busy), 64'd0);

    // Contention: all sources valid, rotation from source 0 after reset
    do_reset(3);
    for (int i = 0; i < 4; i++) present(i, cw[i]);
    for (int n = 0; n < 5; n++) begin
      wait_ack(4'(1 << (n % 4)), "rr_ack");
      check("rr_gap", 64'(out_valid), 64'd0);
      collect(n % 4, cw[n % 4], 8, "rr");
    end
    src_valid = '0;

    // Short word: data_end on byte 5, then a normal word
    short_w = 1;
    present(2, 64'hA1A2_A3A4_A5A6_A7A8);
    wait_ack(4'b0100, "short_ack");
    src_valid = '0;
    collect(2, 64'hA1A2_A3A4_A5A6_A7A8, 5, "short");
    check("short_err_len", 64'(err_len), 64'd1);
    check("short_idle", 64'(busy), 64'd0);
    short_w = 0;
    present(3, 64'hFEDC_BA98_7654_3210);
    wait_ack(4'b1000, "after_short_ack");
    src_valid = '0;
    collect(3, 64'hFEDC_BA98_7654_3210, 8, "after_short");
    check("err_len_sticky", 64'(err_len), 64'd1);

    // Stall: ready never rises, watchdog fires 64 cycles after grant
    stall = 1;
    present(0, 64'h5555_AAAA_5555_AAAA);
    wait_ack(4'b0001, "stall_ack");
    src_valid = '0;
    repeat (63) @(negedge clk);
    check("stall_pre_tmo", 64'(err_timeout), 64'd0);
    check("stall_pre_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("stall_tmo", 64'(err_timeout), 64'd1);
    check("stall_busy", 64'(busy), 64'd0);
    check("stall_req", 64'(ser_req_data), 64'd0);
    check("stall_no_out", 64'(out_valid), 64'd0);
    stall = 0;

    // Reset mid-DRAIN after byte 3
    present(2, 64'h1122_3344_5566_7788);
    wait_ack(4'b0100, "mid_ack");
    src_valid = '0;
    begin
      int t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    check("mid_byte1", 64'(out_data), 64'h88);
    repeat (2) @(negedge clk);
    check("mid_byte3", 64'(out_data), 64'h66);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_req", 64'(ser_req_data), 64'd0);
    check("mid_rst_tmo", 64'(err_timeout), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_hold", 64'(out_valid), 64'd0);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_quiet", 64'(out_valid), 64'd0);
    present(3, cw[3]);
    present(0, cw[0]);
    wait_ack(4'b0001, "post_rst_first");
    src_valid[0] = 1'b0;
    collect(0, cw[0], 8, "post_rst_w0");
    wait_ack(4'b1000, "post_rst_second");
    src_valid[3] = 1'b0;
    collect(3, cw[3], 8, "post_rst_w3");
    check("final_err_len", 64'(err_len), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
